avion_mem_responder: RTL
========================

Name: avion_mem_responder

Overview:
Memory-side responder for the avion_cpu bus (MAR/RAMWr/MDRIn out, MDROut in). It holds a DEPTH x DATA_WIDTH program/data store and answers CPU reads with one-cycle registered latency. It maps two I/O registers into the top of the address space. A streaming loader port fills memory while the CPU is held in reset, so programs are loaded at runtime instead of through initial blocks.

Parameters:
ADDRESS_WIDTH, 6, CPU address width
DATA_WIDTH, 10, word width
DEPTH, 64, memory locations; must equal 2**ADDRESS_WIDTH
IO_OUT_ADDR, 63, address of the write/readable output register
IO_IN_ADDR, 62, address of the read-only input port

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_we  in  1  CPU write enable (RAMWr)
i_addr  in  ADDRESS_WIDTH  CPU address (MAR)
i_ram_data_in  in  DATA_WIDTH  CPU write data (MDRIn)
o_ram_data_out  out  DATA_WIDTH  registered read data (MDROut)
ld_valid  in  1  loader word valid
ld_data  in  DATA_WIDTH  loader word
ld_last  in  1  final loader word, qualified by ld_valid
ld_ready  out  1  loader may transfer
ld_start  in  1  one-cycle pulse: re-enter LOAD from RUN
cpu_hold  out  1  drive into CPU rst; high while loading
ld_done  out  1  high in RUN
ld_overflow  out  1  sticky; load hit DEPTH words without ld_last
io_in  in  DATA_WIDTH  external input word (switches)
io_out  out  DATA_WIDTH  output register (LEDs)

Behaviour:
- Reset (async, immediate):
  - state=LOAD, wr_ptr=0, o_ram_data_out=0, io_out=0, ld_overflow=0.
  - cpu_hold=1, ld_ready=0 while rst high.
  - Memory array is not cleared.
- States:
  - LOAD: ld_ready=1, cpu_hold=1, ld_done=0.
  - RUN: ld_ready=0, cpu_hold=0, ld_done=1.
- All outputs except o_ram_data_out and io_out are decoded from registered state and flags; no combinational path from inputs.
- LOAD:
  - A beat is ld_valid & ld_ready at posedge: memory[wr_ptr] <= ld_data, wr_ptr <= wr_ptr+1.
  - Beat with ld_last=1: go to RUN next cycle and reset wr_ptr to 0.
  - Beat at wr_ptr=DEPTH-1 with ld_last=0: write the word, set ld_overflow, go to RUN, wr_ptr wraps to 0. No write ever wraps onto address 0.
  - CPU i_we is ignored. o_ram_data_out still tracks reads for debug.
  - ld_start is ignored.
- RUN, read path:
  - Every posedge: o_ram_data_out <= rdata(i_addr).
  - rdata = io_in when i_addr==IO_IN_ADDR; io_out when i_addr==IO_OUT_ADDR; memory[i_addr] otherwise.
  - Latency is exactly one cycle: address presented in CPU state 0, data valid for CPU state 1.
  - Read-during-write to the same address returns the OLD value.
- RUN, write path (i_we=1 at posedge):
  - i_addr==IO_OUT_ADDR: io_out <= i_ram_data_in; memory unchanged.
  - i_addr==IO_IN_ADDR: write dropped.
  - Otherwise memory[i_addr] <= i_ram_data_in.
- ld_start in RUN:
  - Next state is LOAD, wr_ptr=0, ld_overflow cleared.
  - A CPU write in the same cycle still completes.
  - io_out is retained.
  - ld_valid/ld_data seen in that same cycle are not captured; ld_ready is still low.
- ld_valid while in RUN: ignored, no write.
- Reset asserted mid-load:
  - Load aborts and wr_ptr returns to 0.
  - Words already written persist in memory.
- Widths: wr_ptr is ADDRESS_WIDTH bits; no arithmetic on data.

Test Plan:
- Reset, stream 13 words (0x033,0x0F1,...,0x240) with ld_last on the 13th, then poke addr 46/48-51 via a second load. Required: ld_done=1 and cpu_hold=0 one cycle after the last beat; reads of addr 0..12 return the loaded words.
- RUN: present i_addr=50 where memory[50]=0x005. Required: o_ram_data_out=0x005 exactly one posedge later, previous value held before that.
- RUN: write 0x032 to addr 63, then read 63. Required: io_out=0x032 after the write edge; read returns 0x032; a later load to addr 63 via the loader shows the memory word is separate. Write to 62, then read 62 with io_in=0x155: returns 0x155.
- Same-cycle write 0x07A and read at addr 20 holding 0x011. Required: o_ram_data_out=0x011; the following read returns 0x07A.
- Stream 64 beats with ld_last=0. Required: memory[63] holds the 64th word, ld_overflow=1, state RUN. ld_start pulse: ld_overflow=0, cpu_hold=1 next cycle.
- Assert rst after 5 of 10 beats, then deassert. Required: wr_ptr=0, cpu_hold=1, o_ram_data_out=0, io_out=0 immediately; memory[0..4] retain the loaded words.

Source files
------------

// File: rtl/avion_mem_responder_if.sv
// CPU memory bus (MAR/RAMWr/MDRIn/MDROut) plus the streaming loader handshake.
// The responder is the slave; the CPU and the loader together act as master.
interface avion_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
);
    logic                     i_we;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0]    i_ram_data_in;
    logic [DATA_WIDTH-1:0]    o_ram_data_out;
    logic                     ld_valid;
    logic [DATA_WIDTH-1:0]    ld_data;
    logic                     ld_last;
    logic                     ld_ready;

    modport master (
        output i_we, i_addr, i_ram_data_in, ld_valid, ld_data, ld_last,
        input  o_ram_data_out, ld_ready
    );

    modport slave (
        input  i_we, i_addr, i_ram_data_in, ld_valid, ld_data, ld_last,
        output o_ram_data_out, ld_ready
    );
endinterface

// File: rtl/avion_mem_responder.sv
// Memory responder for avion_cpu: one-cycle registered reads, two mapped I/O registers,
// and a valid/ready loader that fills memory while the CPU is held in reset.
module avion_mem_responder #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int DEPTH         = 64,
    parameter int IO_OUT_ADDR   = 63,
    parameter int IO_IN_ADDR    = 62
) (
    input  logic                  clk,
    input  logic                  rst,
    avion_mem_responder_if.slave  bus,
    input  logic                  ld_start,
    output logic                  cpu_hold,
    output logic                  ld_done,
    output logic                  ld_overflow,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] io_out
);
    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OUT_A    = ADDRESS_WIDTH'(IO_OUT_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] IN_A     = ADDRESS_WIDTH'(IO_IN_ADDR);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic                     ovf_nxt;
    logic                     rst_done;
    logic                     beat;
    logic                     run_wr;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    rdata;

    // rst_done keeps ld_ready low while rst is high without a combinational path from rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    assign bus.ld_ready = (state == S_LOAD) && rst_done;
    assign cpu_hold     = (state != S_RUN);
    assign ld_done      = (state == S_RUN);
    assign beat         = bus.ld_valid && bus.ld_ready;
    assign run_wr       = (state == S_RUN) && bus.i_we;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        ovf_nxt    = ld_overflow;
        case (state)
            S_LOAD: begin
                if (beat) begin
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    if (bus.ld_last) begin
                        state_nxt  = S_RUN;
                        wr_ptr_nxt = '0;
                    end else if (wr_ptr == LAST_PTR) begin
                        state_nxt  = S_RUN;
                        wr_ptr_nxt = '0;
                        ovf_nxt    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ld_start) begin
                    state_nxt  = S_LOAD;
                    wr_ptr_nxt = '0;
                    ovf_nxt    = 1'b0;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            ld_overflow <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            ld_overflow <= ovf_nxt;
        end
    end

    // Loader and CPU writes never coincide: each is gated by a different state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.i_addr;
        mem_wdata = bus.i_ram_data_in;
        if (beat) begin
            mem_we    = 1'b1;
            mem_waddr = wr_ptr;
            mem_wdata = bus.ld_data;
        end else if (run_wr && bus.i_addr != OUT_A && bus.i_addr != IN_A) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                io_out <= '0;
        else if (run_wr && bus.i_addr == OUT_A) io_out <= bus.i_ram_data_in;
    end

    always_comb begin
        if (bus.i_addr == IN_A)       rdata = io_in;
        else if (bus.i_addr == OUT_A) rdata = io_out;
        else                          rdata = mem[bus.i_addr];
    end

    // Registered read sees pre-edge contents, so read-during-write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.o_ram_data_out <= '0;
        else     bus.o_ram_data_out <= rdata;
    end
endmodule
